// File: rtl/elev_pkg.sv
// Shared types and constants for the elevator LOOK scheduler.
package elev_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    DOOR  = 2'd2,
    CLOSE = 2'd3
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int N_FLOORS_DEF = 5;

endpackage

// File: rtl/elev_req_latch.sv
// Sticky per-floor request register: a pulse sets a bit, which then holds
// until the scheduler clears it. Clear beats a simultaneous set; the scheduler
// only raises clear while the car is servicing that floor. Bits outside KEEP
// never latch (unused hall buttons at the end floors).
module elev_req_latch #(
  parameter int             N    = 5,
  parameter logic [N-1:0]   KEEP = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] set,
  input  logic [N-1:0] clr,
  output logic [N-1:0] pend
);

  // Accumulate new calls and drop the ones being serviced.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) pend <= '0;
    else        pend <= (pend | set) & ~clr & KEEP;
  end

endmodule

// File: rtl/elevator_look_scheduler.sv
// Single-car LOOK scheduler: latches calls, keeps travelling while calls lie
// ahead, reverses or idles otherwise, and runs a timed door dwell per stop.
// Optional build macro ELEV_DOOR_HOLD_EN adds a door_hold input that freezes
// the dwell in DOOR and re-opens the door from CLOSE.
module elevator_look_scheduler
  import elev_pkg::*;
#(
  parameter int  N_FLOORS     = N_FLOORS_DEF,
  parameter int  DWELL_CYCLES = 8,
  localparam int FLOOR_W      = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] cab_req,
  input  logic [N_FLOORS-1:0] hall_up_req,
  input  logic [N_FLOORS-1:0] hall_dn_req,
  input  logic [FLOOR_W-1:0]  floor_cur,
  input  logic                floor_aligned,
  input  logic                door_closed,
`ifdef ELEV_DOOR_HOLD_EN
  input  logic                door_hold,
`endif
  output logic                motor,
  output logic                direction,
  output logic                door_open_cmd,
  output logic [N_FLOORS-1:0] pend_cab,
  output logic [N_FLOORS-1:0] pend_up,
  output logic [N_FLOORS-1:0] pend_dn,
  output logic                busy
);

  localparam int                  CNT_W   = $clog2(DWELL_CYCLES + 1);
  localparam logic [CNT_W-1:0]    RELOAD  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [FLOOR_W-1:0]  TOP     = FLOOR_W'(N_FLOORS - 1);
  localparam logic [N_FLOORS-1:0] UP_KEEP = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] DN_KEEP = {{(N_FLOORS-1){1'b1}}, 1'b0};

  state_t               state, next_state, dec_state;
  logic [CNT_W-1:0]     dwell_cnt, next_cnt;
  logic                 next_dir, dec_dir;
  logic [N_FLOORS-1:0]  cur_oh, above_m, below_m, pend_all;
  logic [N_FLOORS-1:0]  clr_cab, clr_up, clr_dn;
  logic                 above, below, ahead, cab_at, up_at, dn_at;
  logic                 up_ok, dn_ok, serv_here, req_here, at_limit, stop_now, clr_en;
  logic                 hold;

`ifdef ELEV_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  // Floor position masks relative to the car.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cur_oh  = '0;
    above_m = '0;
    below_m = '0;
    for (int f = 0; f < N_FLOORS; f++) begin
      cur_oh[f]  = (FLOOR_W'(f) == floor_cur);
      above_m[f] = (FLOOR_W'(f) >  floor_cur);
      below_m[f] = (FLOOR_W'(f) <  floor_cur);
    end
  end

  assign pend_all = pend_cab | pend_up | pend_dn;
  assign above    = |(pend_all & above_m);
  assign below    = |(pend_all & below_m);
  assign ahead    = (direction == DIR_UP) ? above : below;
  assign cab_at   = |(pend_cab & cur_oh);
  assign up_at    = |(pend_up  & cur_oh);
  assign dn_at    = |(pend_dn  & cur_oh);

  // Hall calls at this floor are only serviced when the car will leave in
  // their direction, or when nothing is left on the other side.
  assign up_ok     = (direction == DIR_UP) || !below;
  assign dn_ok     = (direction == DIR_DN) || !above;
  assign serv_here = cab_at | (up_at & up_ok) | (dn_at & dn_ok);
  assign req_here  = |(cab_req & cur_oh)
                   | (|(hall_up_req & UP_KEEP & cur_oh) & up_ok)
                   | (|(hall_dn_req & DN_KEEP & cur_oh) & dn_ok);

  assign at_limit = (direction == DIR_UP) ? (floor_cur == TOP) : (floor_cur == '0);
  assign stop_now = at_limit
                  || (floor_aligned && (cab_at
                                        || (direction == DIR_UP && up_at)
                                        || (direction == DIR_DN && dn_at)
                                        || !ahead));

  // LOOK decision. "Here" counts only calls the door cycle will actually
  // clear, so a wrong-direction hall call cannot trap the car in DOOR/CLOSE.
  always_comb begin
    dec_state = IDLE;
    dec_dir   = direction;
    if (serv_here) begin
      dec_state = DOOR;
    end else if (ahead) begin
      dec_state = MOVE;
    end else if (above || below) begin
      dec_state = MOVE;
      dec_dir   = ~direction;
    end
  end

  // Next-state, dwell counter and direction.
  always_comb begin
    next_state = state;
    next_cnt   = dwell_cnt;
    next_dir   = direction;
    case (state)
      IDLE: begin
        next_state = dec_state;
        next_dir   = dec_dir;
      end
      MOVE: begin
        if (stop_now) next_state = serv_here ? DOOR : IDLE;
      end
      DOOR: begin
        if (req_here || hold)     next_cnt   = RELOAD;
        else if (dwell_cnt == '0) next_state = CLOSE;
        else                      next_cnt   = dwell_cnt - 1'b1;
      end
      CLOSE: begin
        if (req_here || hold) begin
          next_state = DOOR;
        end else if (door_closed) begin
          next_state = dec_state;
          next_dir   = dec_dir;
        end
      end
      default: next_state = IDLE;
    endcase
    if (next_state == DOOR && state != DOOR) next_cnt = RELOAD;
  end

  // Calls at the current floor are cleared on DOOR entry and absorbed while
  // the door cycle is running there.
  assign clr_en  = (next_state == DOOR) || (state == DOOR) || (state == CLOSE);
  assign clr_cab = clr_en           ? cur_oh : '0;
  assign clr_up  = (clr_en && up_ok) ? cur_oh : '0;
  assign clr_dn  = (clr_en && dn_ok) ? cur_oh : '0;

  elev_req_latch #(.N(N_FLOORS), .KEEP({N_FLOORS{1'b1}})) u_cab (
    .clk(clk), .rst_n(rst_n), .set(cab_req), .clr(clr_cab), .pend(pend_cab)
  );
  elev_req_latch #(.N(N_FLOORS), .KEEP(UP_KEEP)) u_up (
    .clk(clk), .rst_n(rst_n), .set(hall_up_req), .clr(clr_up), .pend(pend_up)
  );
  elev_req_latch #(.N(N_FLOORS), .KEEP(DN_KEEP)) u_dn (
    .clk(clk), .rst_n(rst_n), .set(hall_dn_req), .clr(clr_dn), .pend(pend_dn)
  );

  // State register with outputs registered from the next-state decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      dwell_cnt     <= '0;
      motor         <= 1'b0;
      direction     <= DIR_UP;
      door_open_cmd <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= next_state;
      dwell_cnt     <= next_cnt;
      motor         <= (next_state == MOVE);
      direction     <= next_dir;
      door_open_cmd <= (next_state == DOOR);
      busy          <= (next_state != IDLE);
    end
  end

`ifndef SYNTHESIS
  motor_door_safe_a: assert property (@(posedge clk) disable iff (!rst_n)
    motor |-> (!door_open_cmd && door_closed));
`endif

endmodule

// File: tb/tb_elevator_look_scheduler.sv
// Directed bench for elevator_look_scheduler (5 floors, dwell 8).
module tb_elevator_look_scheduler;
  import elev_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] cab_req, hall_up_req, hall_dn_req;
  logic [2:0] floor_cur;
  logic       floor_aligned, door_closed, door_hold;
  logic       motor, direction, door_open_cmd, busy;
  logic [4:0] pend_cab, pend_up, pend_dn;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  elevator_look_scheduler #(.N_FLOORS(5), .DWELL_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cab_req(cab_req), .hall_up_req(hall_up_req), .hall_dn_req(hall_dn_req),
    .floor_cur(floor_cur), .floor_aligned(floor_aligned), .door_closed(door_closed),
`ifdef ELEV_DOOR_HOLD_EN
    .door_hold(door_hold),
`endif
    .motor(motor), .direction(direction), .door_open_cmd(door_open_cmd),
    .pend_cab(pend_cab), .pend_up(pend_up), .pend_dn(pend_dn), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Count cycles until the door drops, bounded.
  task automatic wait_close(output int cnt);
    cnt = 0;
    while (door_open_cmd && cnt < 40) begin
      step(1);
      cnt++;
    end
  endtask

  task automatic do_reset(input logic [2:0] f);
    rst_n = 1'b0;
    cab_req = '0; hall_up_req = '0; hall_dn_req = '0;
    floor_cur = f; floor_aligned = 1'b1; door_closed = 1'b1; door_hold = 1'b0;
    step(2);
    check("rst_motor", motor, 0);
    check("rst_dir", direction, 1);
    check("rst_door", door_open_cmd, 0);
    check("rst_pend", {pend_cab, pend_up, pend_dn}, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic pulse_cab(input logic [4:0] v);
    cab_req = v; step(1); cab_req = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    // T1: single cab call from floor 0 to floor 3.
    do_reset(3'd0);
    pulse_cab(5'b01000);
    check("t1_pend_cab", pend_cab, 5'b01000);
    check("t1_motor_early", motor, 0);
    step(1);
    check("t1_motor", motor, 1);
    check("t1_dir", direction, 1);
    floor_cur = 3'd1; step(1);
    floor_cur = 3'd2; step(1);
    check("t1_pass2", motor, 1);
    floor_cur = 3'd3; step(1);
    check("t1_stop_motor", motor, 0);
    check("t1_stop_door", door_open_cmd, 1);
    check("t1_clr_cab", pend_cab, 0);
    wait_close(n);
    check("t1_dwell", n, 8);
    step(1);
    check("t1_idle", busy, 0);

    // T2: hall down at 2 is passed going up, serviced after reversing at 4.
    do_reset(3'd1);
    cab_req = 5'b10000; hall_dn_req = 5'b00100; step(1);
    cab_req = '0; hall_dn_req = '0;
    check("t2_pend_cab", pend_cab, 5'b10000);
    check("t2_pend_dn", pend_dn, 5'b00100);
    step(1);
    check("t2_motor", motor, 1);
    check("t2_dir_up", direction, 1);
    floor_cur = 3'd2; step(1);
    check("t2_no_stop2", motor, 1);
    floor_cur = 3'd3; step(1);
    floor_cur = 3'd4; step(1);
    check("t2_stop4", door_open_cmd, 1);
    check("t2_pend_dn_kept", pend_dn, 5'b00100);
    wait_close(n);
    check("t2_dwell", n, 8);
    step(1);
    check("t2_rev_motor", motor, 1);
    check("t2_rev_dir", direction, 0);
    floor_cur = 3'd3; step(1);
    check("t2_pass3", motor, 1);
    floor_cur = 3'd2; step(1);
    check("t2_stop2_motor", motor, 0);
    check("t2_stop2_door", door_open_cmd, 1);
    check("t2_clr_dn", pend_dn, 0);

    // T3: hall up at the idle floor opens the door; repeat call reloads dwell.
    do_reset(3'd2);
    hall_up_req = 5'b00100; step(1); hall_up_req = '0;
    check("t3_pend_up", pend_up, 5'b00100);
    step(1);
    check("t3_door", door_open_cmd, 1);
    check("t3_no_motor", motor, 0);
    check("t3_clr_up", pend_up, 0);
    check("t3_cnt7", dut.dwell_cnt, 7);
    step(6);
    check("t3_cnt1", dut.dwell_cnt, 1);
    hall_up_req = 5'b00100; step(1); hall_up_req = '0;
    check("t3_reload", dut.dwell_cnt, 7);
    check("t3_absorbed", pend_up, 0);
    wait_close(n);
    check("t3_dwell", n, 8);

    // T4: spurious top-floor reading while going up forces a stop.
    do_reset(3'd0);
    pulse_cab(5'b01000);
    step(1);
    check("t4_motor", motor, 1);
    floor_cur = 3'd4; floor_aligned = 1'b0; step(1);
    check("t4_limit_motor", motor, 0);
    check("t4_limit_idle", busy, 0);
    check("t4_dir_kept", direction, 1);
    step(1);
    check("t4_rev_motor", motor, 1);
    check("t4_rev_dir", direction, 0);

    // T5: asynchronous reset while moving with a pending call.
    rst_n = 1'b0; #1;
    check("t5_async_motor", motor, 0);
    check("t5_async_pend", pend_cab, 0);
    step(1);
    rst_n = 1'b1; floor_aligned = 1'b1; floor_cur = 3'd3;
    step(1);
    check("t5_state", 32'(dut.state), 32'(IDLE));
    check("t5_busy", busy, 0);

    // T6: ignored hall bits; CLOSE waits on door_closed and re-opens on a call.
    do_reset(3'd2);
    hall_up_req = 5'b10000; hall_dn_req = 5'b00001; step(1);
    hall_up_req = '0; hall_dn_req = '0;
    check("t6_ign_up", pend_up, 0);
    check("t6_ign_dn", pend_dn, 0);
    step(1);
    check("t6_still_idle", busy, 0);
    pulse_cab(5'b00100);
    step(1);
    check("t6_door", door_open_cmd, 1);
    door_closed = 1'b0;
    wait_close(n);
    check("t6_dwell", n, 8);
    step(3);
    check("t6_wait_busy", busy, 1);
    check("t6_wait_door", door_open_cmd, 0);
    pulse_cab(5'b00100);
    check("t6_reopen", door_open_cmd, 1);
    check("t6_absorbed", pend_cab, 0);
    door_closed = 1'b1;
    wait_close(n);
    check("t6_dwell2", n, 8);
    step(1);
    check("t6_idle", busy, 0);

`ifdef ELEV_DOOR_HOLD_EN
    // T7: door_hold freezes the dwell, release lets it run out.
    do_reset(3'd1);
    pulse_cab(5'b00010);
    step(1);
    check("t7_door", door_open_cmd, 1);
    door_hold = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (door_open_cmd) n++;
    end
    check("t7_held", n, 20);
    door_hold = 1'b0;
    wait_close(n);
    check("t7_dwell", n, 8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
